// File: rtl/sodor5_commit_checker.sv
// Lockstep retirement checker: buffers model (A) and core (B) writebacks, compares heads in order.
// Latency: an entry pushed in cycle N is compared in cycle N+1; results appear one cycle later.
// Backpressure: none upstream; a push into a full FIFO is an overflow error, and FAIL freezes all state.
module sodor5_commit_checker #(
  parameter  int WORD_SIZE = 32,
  parameter  int NUM_REGS  = 32,
  parameter  int DEPTH     = 8,
  parameter  int TIMEOUT   = 64,
  localparam int RW        = $clog2(NUM_REGS),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 a_wb_valid,
  input  logic [RW-1:0]        a_wb_rd,
  input  logic [WORD_SIZE-1:0] a_wb_data,
  input  logic                 b_wb_valid,
  input  logic [RW-1:0]        b_wb_rd,
  input  logic [WORD_SIZE-1:0] b_wb_data,
  input  logic                 clear,
  output logic [31:0]          commits,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [RW-1:0]        err_rd_a,
  output logic [WORD_SIZE-1:0] err_data_a,
  output logic [RW-1:0]        err_rd_b,
  output logic [WORD_SIZE-1:0] err_data_b,
  output logic [CW-1:0]        pending_a,
  output logic [CW-1:0]        pending_b
);

  localparam int PW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {S_CHECK = 1'b0, S_FAIL = 1'b1} state_t;

  state_t r_state, w_state_nxt;

  logic [RW-1:0]        r_a_rd  [DEPTH];
  logic [WORD_SIZE-1:0] r_a_dat [DEPTH];
  logic [RW-1:0]        r_b_rd  [DEPTH];
  logic [WORD_SIZE-1:0] r_b_dat [DEPTH];
  logic [PW-1:0]        r_a_wp, r_a_rp, r_b_wp, r_b_rp;
  logic [CW-1:0]        r_a_cnt, r_b_cnt;
  logic [TW-1:0]        r_to_cnt;
  logic [31:0]          r_commits;
  logic                 r_err;
  logic [1:0]           r_err_code;
  logic [RW-1:0]        r_err_rd_a, r_err_rd_b;
  logic [WORD_SIZE-1:0] r_err_data_a, r_err_data_b;

  logic w_chk, w_a_ne, w_b_ne, w_pop, w_match, w_mis;
  logic w_a_req, w_b_req, w_a_ovf, w_b_ovf, w_ovf, w_a_push, w_b_push;
  logic w_one, w_to_inc, w_to;

  // Head compare, push/overflow qualification and timeout detection; clear suppresses all activity.
  always_comb begin
    w_chk    = (r_state == S_CHECK) && !clear;
    w_a_ne   = (r_a_cnt != '0);
    w_b_ne   = (r_b_cnt != '0);
    w_pop    = w_chk && w_a_ne && w_b_ne;
    w_match  = (r_a_rd[r_a_rp] == r_b_rd[r_b_rp]) && (r_a_dat[r_a_rp] == r_b_dat[r_b_rp]);
    w_mis    = w_pop && !w_match;
    w_a_req  = w_chk && a_wb_valid && (a_wb_rd != '0);
    w_b_req  = w_chk && b_wb_valid && (b_wb_rd != '0);
    // Popping frees a slot in the same cycle, so push+pop at full is legal.
    w_a_ovf  = w_a_req && (r_a_cnt == CW'(DEPTH)) && !w_pop;
    w_b_ovf  = w_b_req && (r_b_cnt == CW'(DEPTH)) && !w_pop;
    w_ovf    = w_a_ovf || w_b_ovf;
    w_a_push = w_a_req && !w_a_ovf;
    w_b_push = w_b_req && !w_b_ovf;
    w_one    = w_chk && (w_a_ne ^ w_b_ne);
    w_to_inc = w_one && (TIMEOUT != 0);
    // Fire on the cycle the counter would reach TIMEOUT, so the error lands TIMEOUT cycles after skew began.
    w_to     = w_to_inc && (r_to_cnt == TW'(TIMEOUT - 1));
  end

  // Next state: any error freezes the checker; only clear returns to CHECK.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_CHECK;
    end else if ((r_state == S_CHECK) && (w_mis || w_ovf || w_to)) begin
      w_state_nxt = S_FAIL;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_CHECK;
    else          r_state <= w_state_nxt;
  end

  // FIFO storage; contents need no reset because pointers/counts define validity.
  always_ff @(posedge clk) begin
    if (w_a_push) begin
      r_a_rd[r_a_wp]  <= a_wb_rd;
      r_a_dat[r_a_wp] <= a_wb_data;
    end
    if (w_b_push) begin
      r_b_rd[r_b_wp]  <= b_wb_rd;
      r_b_dat[r_b_wp] <= b_wb_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_wp <= '0; r_a_rp <= '0; r_a_cnt <= '0;
      r_b_wp <= '0; r_b_rp <= '0; r_b_cnt <= '0;
    end else if (clear) begin
      r_a_wp <= '0; r_a_rp <= '0; r_a_cnt <= '0;
      r_b_wp <= '0; r_b_rp <= '0; r_b_cnt <= '0;
    end else begin
      if (w_a_push) r_a_wp <= r_a_wp + 1'b1;
      if (w_b_push) r_b_wp <= r_b_wp + 1'b1;
      if (w_pop) begin
        r_a_rp <= r_a_rp + 1'b1;
        r_b_rp <= r_b_rp + 1'b1;
      end
      r_a_cnt <= r_a_cnt + CW'(w_a_push) - CW'(w_pop);
      r_b_cnt <= r_b_cnt + CW'(w_b_push) - CW'(w_pop);
    end
  end

  // Skew timer: counts consecutive one-sided cycles in CHECK, holds in FAIL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_to_cnt <= '0;
    else if (clear)    r_to_cnt <= '0;
    else if (w_chk)    r_to_cnt <= w_to_inc ? r_to_cnt + 1'b1 : '0;
  end

  // Commit counter and prioritised error capture (mismatch > overflow > timeout).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || clear) begin
      r_commits    <= '0;
      r_err        <= 1'b0;
      r_err_code   <= 2'b00;
      r_err_rd_a   <= '0;
      r_err_data_a <= '0;
      r_err_rd_b   <= '0;
      r_err_data_b <= '0;
    end else if (w_chk) begin
      if (w_pop && w_match && (r_commits != 32'hFFFF_FFFF)) r_commits <= r_commits + 32'd1;
      if (w_mis) begin
        r_err        <= 1'b1;
        r_err_code   <= 2'b01;
        r_err_rd_a   <= r_a_rd[r_a_rp];
        r_err_data_a <= r_a_dat[r_a_rp];
        r_err_rd_b   <= r_b_rd[r_b_rp];
        r_err_data_b <= r_b_dat[r_b_rp];
      end else if (w_ovf) begin
        r_err      <= 1'b1;
        r_err_code <= 2'b10;
      end else if (w_to) begin
        r_err      <= 1'b1;
        r_err_code <= 2'b11;
      end
    end
  end

  assign commits    = r_commits;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign err_rd_a   = r_err_rd_a;
  assign err_data_a = r_err_data_a;
  assign err_rd_b   = r_err_rd_b;
  assign err_data_b = r_err_data_b;
  assign pending_a  = r_a_cnt;
  assign pending_b  = r_b_cnt;

endmodule

// File: tb/tb_sodor5_commit_checker.sv
// Directed bench for sodor5_commit_checker: each task drives one scenario and checks inline.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at the same point.
// Counters n_checks / n_fail feed the single summary line.
module tb_sodor5_commit_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_wb_valid, b_wb_valid, clear;
  logic [4:0]  a_wb_rd, b_wb_rd;
  logic [31:0] a_wb_data, b_wb_data;
  logic [31:0] commits;
  logic        err;
  logic [1:0]  err_code;
  logic [4:0]  err_rd_a, err_rd_b;
  logic [31:0] err_data_a, err_data_b;
  logic [3:0]  pending_a, pending_b;

  int n_checks = 0;
  int n_fail   = 0;

  sodor5_commit_checker #(.WORD_SIZE(32), .NUM_REGS(32), .DEPTH(8), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_wb_valid(a_wb_valid), .a_wb_rd(a_wb_rd), .a_wb_data(a_wb_data),
    .b_wb_valid(b_wb_valid), .b_wb_rd(b_wb_rd), .b_wb_data(b_wb_data),
    .clear(clear), .commits(commits), .err(err), .err_code(err_code),
    .err_rd_a(err_rd_a), .err_data_a(err_data_a),
    .err_rd_b(err_rd_b), .err_data_b(err_data_b),
    .pending_a(pending_a), .pending_b(pending_b)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    a_wb_valid = 1'b0; a_wb_rd = '0; a_wb_data = '0;
    b_wb_valid = 1'b0; b_wb_rd = '0; b_wb_data = '0;
  endtask

  task automatic drive_a(input logic [4:0] rd, input logic [31:0] d);
    a_wb_valid = 1'b1; a_wb_rd = rd; a_wb_data = d;
  endtask

  task automatic drive_b(input logic [4:0] rd, input logic [31:0] d);
    b_wb_valid = 1'b1; b_wb_rd = rd; b_wb_data = d;
  endtask

  task automatic do_clear;
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; clear = 1'b0; idle();
    #3;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b want 0", err); end
    n_checks++; if (commits !== 32'd0) begin n_fail++; $display("FAIL reset_commits got %0d want 0", commits); end
    n_checks++; if (pending_a !== 4'd0 || pending_b !== 4'd0) begin n_fail++; $display("FAIL reset_pending got %0d/%0d want 0/0", pending_a, pending_b); end
    n_checks++; if (err_code !== 2'b00 || err_data_a !== 32'd0 || err_rd_b !== 5'd0) begin n_fail++; $display("FAIL reset_errinfo code %0b data_a %h rd_b %0d want 0", err_code, err_data_a, err_rd_b); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    n_checks++; if (err !== 1'b0 || commits !== 32'd0) begin n_fail++; $display("FAIL post_reset got err %0b commits %0d want 0/0", err, commits); end
  endtask

  task automatic test_single_match;
    do_clear();
    drive_a(5'd5, 32'h0000_1234); drive_b(5'd5, 32'h0000_1234);
    tick(); idle();
    n_checks++; if (pending_a !== 4'd1 || pending_b !== 4'd1) begin n_fail++; $display("FAIL single_pending1 got %0d/%0d want 1/1", pending_a, pending_b); end
    n_checks++; if (commits !== 32'd0) begin n_fail++; $display("FAIL single_commits1 got %0d want 0", commits); end
    tick();
    n_checks++; if (commits !== 32'd1) begin n_fail++; $display("FAIL single_commits2 got %0d want 1", commits); end
    n_checks++; if (pending_a !== 4'd0 || pending_b !== 4'd0 || err !== 1'b0) begin n_fail++; $display("FAIL single_after got %0d/%0d err %0b want 0/0 err 0", pending_a, pending_b, err); end
  endtask

  task automatic test_skew;
    int peak = 0;
    do_clear();
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c <= 3) drive_b(5'(c + 1), 32'h100 + 32'(c + 1));
      if (c >= 2 && c <= 5) drive_a(5'(c - 1), 32'h100 + 32'(c - 1));
      tick();
      if (int'(pending_b) > peak) peak = int'(pending_b);
    end
    idle();
    n_checks++; if (peak != 3) begin n_fail++; $display("FAIL skew_peak got %0d want 3", peak); end
    n_checks++; if (commits !== 32'd4) begin n_fail++; $display("FAIL skew_commits got %0d want 4", commits); end
    n_checks++; if (err !== 1'b0 || pending_a !== 4'd0 || pending_b !== 4'd0) begin n_fail++; $display("FAIL skew_final err %0b pending %0d/%0d want 0 0/0", err, pending_a, pending_b); end
  endtask

  task automatic test_mismatch;
    do_clear();
    drive_a(5'd7, 32'h0000_AAAA); drive_b(5'd7, 32'h0000_AAAB);
    tick(); idle();
    tick();
    n_checks++; if (err !== 1'b1 || err_code !== 2'b01) begin n_fail++; $display("FAIL mis_code got err %0b code %0b want 1 01", err, err_code); end
    n_checks++; if (err_rd_a !== 5'd7 || err_rd_b !== 5'd7) begin n_fail++; $display("FAIL mis_rd got %0d/%0d want 7/7", err_rd_a, err_rd_b); end
    n_checks++; if (err_data_a !== 32'h0000_AAAA) begin n_fail++; $display("FAIL mis_data_a got %h want 0000aaaa", err_data_a); end
    n_checks++; if (err_data_b !== 32'h0000_AAAB) begin n_fail++; $display("FAIL mis_data_b got %h want 0000aaab", err_data_b); end
    n_checks++; if (commits !== 32'd0) begin n_fail++; $display("FAIL mis_commits got %0d want 0", commits); end
  endtask

  task automatic test_overflow;
    do_clear();
    for (int i = 1; i <= 9; i++) begin
      idle();
      drive_b(5'(i), 32'(i * 16));
      tick();
      if (i == 8) begin
        n_checks++; if (pending_b !== 4'd8 || err !== 1'b0) begin n_fail++; $display("FAIL ovf_full got pending %0d err %0b want 8 0", pending_b, err); end
      end
    end
    idle();
    n_checks++; if (err !== 1'b1 || err_code !== 2'b10) begin n_fail++; $display("FAIL ovf_code got err %0b code %0b want 1 10", err, err_code); end
    n_checks++; if (pending_b !== 4'd8 || err_data_b !== 32'd0) begin n_fail++; $display("FAIL ovf_state got pending %0d data_b %h want 8 0", pending_b, err_data_b); end
  endtask

  task automatic test_timeout;
    do_clear();
    drive_a(5'd3, 32'h33);
    tick();
    drive_a(5'd0, 32'hDEAD);
    n_checks++; if (pending_a !== 4'd1) begin n_fail++; $display("FAIL to_start got pending %0d want 1", pending_a); end
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 63) begin
        n_checks++; if (err !== 1'b0 || pending_a !== 4'd1) begin n_fail++; $display("FAIL to_early got err %0b pending %0d want 0 1", err, pending_a); end
      end
    end
    n_checks++; if (err !== 1'b1 || err_code !== 2'b11) begin n_fail++; $display("FAIL to_code got err %0b code %0b want 1 11", err, err_code); end
    drive_a(5'd4, 32'h44);
    tick(); idle();
    n_checks++; if (pending_a !== 4'd1 || err_code !== 2'b11) begin n_fail++; $display("FAIL to_frozen got pending %0d code %0b want 1 11", pending_a, err_code); end
  endtask

  task automatic test_back_to_back;
    do_clear();
    for (int c = 0; c < 5; c++) begin
      drive_a(5'(c + 10), 32'hC0DE_0000 + 32'(c));
      drive_b(5'(c + 10), 32'hC0DE_0000 + 32'(c));
      tick();
      if (c == 0) begin
        n_checks++; if (pending_a !== 4'd1 || pending_b !== 4'd1 || commits !== 32'd0) begin n_fail++; $display("FAIL b2b_first got %0d/%0d commits %0d want 1/1 0", pending_a, pending_b, commits); end
      end
    end
    idle();
    n_checks++; if (commits !== 32'd4 || pending_a !== 4'd1) begin n_fail++; $display("FAIL b2b_mid got commits %0d pending %0d want 4 1", commits, pending_a); end
    tick();
    n_checks++; if (commits !== 32'd5 || pending_a !== 4'd0 || pending_b !== 4'd0) begin n_fail++; $display("FAIL b2b_end got commits %0d pending %0d/%0d want 5 0/0", commits, pending_a, pending_b); end
  endtask

  task automatic test_async_reset_and_clear;
    do_clear();
    drive_a(5'd1, 32'h11); tick();
    drive_a(5'd2, 32'h22); tick();
    idle();
    n_checks++; if (pending_a !== 4'd2) begin n_fail++; $display("FAIL ar_pending got %0d want 2", pending_a); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (pending_a !== 4'd0 || commits !== 32'd0 || err !== 1'b0) begin n_fail++; $display("FAIL ar_zero got pending %0d commits %0d err %0b want 0 0 0", pending_a, commits, err); end
    #5 reset_n = 1'b1;
    tick();
    drive_a(5'd7, 32'h1); drive_b(5'd7, 32'h2);
    tick(); idle(); tick();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL cl_fail got err %0b want 1", err); end
    drive_a(5'd9, 32'h99); drive_b(5'd9, 32'h99);
    clear = 1'b1;
    tick();
    clear = 1'b0; idle();
    n_checks++; if (err !== 1'b0 || err_code !== 2'b00 || err_data_a !== 32'd0) begin n_fail++; $display("FAIL cl_err got err %0b code %0b data_a %h want 0", err, err_code, err_data_a); end
    n_checks++; if (pending_a !== 4'd0 || pending_b !== 4'd0) begin n_fail++; $display("FAIL cl_discard got %0d/%0d want 0/0", pending_a, pending_b); end
    drive_a(5'd9, 32'h99); drive_b(5'd9, 32'h99);
    tick(); idle(); tick();
    n_checks++; if (commits !== 32'd1 || err !== 1'b0) begin n_fail++; $display("FAIL cl_resume got commits %0d err %0b want 1 0", commits, err); end
  endtask

  initial begin
    test_reset();
    test_single_match();
    test_skew();
    test_mismatch();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_async_reset_and_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
